// File: rtl/bus_arbiter_if.sv
// Shared-memory arbiter bus bundle: CPU, Maria DMA and host requesters,
// the arbitrated memory bus and the halt/ownership status outputs.
interface bus_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              enable;
    logic              cpu_cycle_end;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_we;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_gnt;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_we;
    logic              host_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              halt_b;
    logic [1:0]        owner;
    logic [15:0]       halt_cycles;

    // Arbiter side
    modport slave (
        input  enable, cpu_cycle_end, cpu_addr, cpu_wdata, cpu_we,
        input  dma_req, dma_addr, host_req, host_addr, host_wdata, host_we,
        output dma_gnt, host_gnt, mem_addr, mem_wdata, mem_we,
        output halt_b, owner, halt_cycles
    );

    // Requester / system side
    modport master (
        output enable, cpu_cycle_end, cpu_addr, cpu_wdata, cpu_we,
        output dma_req, dma_addr, host_req, host_addr, host_wdata, host_we,
        input  dma_gnt, host_gnt, mem_addr, mem_wdata, mem_we,
        input  halt_b, owner, halt_cycles
    );
endinterface

// File: rtl/bus_arbiter.sv
// Shared memory arbiter: the 6502 owns the bus until DMA or host asks for it;
// the CPU is then halted, a fixed latency elapses, and grants are handed out
// (DMA before host). After the last grant the bus idles through a cooldown and
// is returned to the CPU only on a 6502 cycle boundary.
module bus_arbiter #(
    parameter int HALT_LATENCY = 12,
    parameter int COOLDOWN     = 1,
    parameter int ADDR_W       = 16
) (
    input  logic          sysclk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    // Zero would collapse the wait/cooldown phases, so both floor at one.
    localparam int HL    = (HALT_LATENCY < 1) ? 1 : HALT_LATENCY;
    localparam int CD    = (COOLDOWN < 1) ? 1 : COOLDOWN;
    localparam int CTR_W = $clog2(HL + 1);
    localparam int CD_W  = $clog2(CD + 1);
    localparam logic [CTR_W-1:0] HL_C = CTR_W'(HL);
    localparam logic [CD_W-1:0]  CD_C = CD_W'(CD);

    typedef enum logic [2:0] {
        S_CPU, S_HALT_WAIT, S_DMA, S_HOST, S_RELEASE
    } state_t;

    state_t            state, state_nx;
    logic [CTR_W-1:0]  ctr, ctr_nx;
    logic [CD_W-1:0]   cool, cool_nx;
    logic              halt_nx, dma_gnt_nx, host_gnt_nx;
    logic [1:0]        owner_nx;
    logic [15:0]       hc_nx;
    logic              dma_act;

    assign dma_act = bus.dma_req & bus.enable;

    // Next state, counters, and the registered output values for next cycle
    always_comb begin
        state_nx = state;
        ctr_nx   = ctr;
        cool_nx  = cool;
        case (state)
            S_CPU: begin
                if (dma_act || bus.host_req) begin
                    state_nx = S_HALT_WAIT;
                    ctr_nx   = CTR_W'(1);
                end
            end
            S_HALT_WAIT: begin
                if (ctr == HL_C) begin
                    ctr_nx = '0;
                    if (dma_act)           state_nx = S_DMA;
                    else if (bus.host_req) state_nx = S_HOST;
                    else begin
                        state_nx = S_RELEASE;
                        cool_nx  = CD_C;
                    end
                end else begin
                    ctr_nx = ctr + CTR_W'(1);
                end
            end
            S_DMA: begin
                if (!dma_act) begin
                    if (bus.host_req) state_nx = S_HOST;
                    else begin
                        state_nx = S_RELEASE;
                        cool_nx  = CD_C;
                    end
                end
            end
            S_HOST: begin
                if (dma_act) state_nx = S_DMA;
                else if (!bus.host_req) begin
                    state_nx = S_RELEASE;
                    cool_nx  = CD_C;
                end
            end
            S_RELEASE: begin
                // New requests reclaim the bus directly; the CPU is still halted.
                if (dma_act)                state_nx = S_DMA;
                else if (bus.host_req)      state_nx = S_HOST;
                else if (cool != '0)        cool_nx  = cool - CD_W'(1);
                else if (bus.cpu_cycle_end) state_nx = S_CPU;
            end
            default: state_nx = S_CPU;
        endcase

        halt_nx     = (state_nx == S_CPU);
        dma_gnt_nx  = (state_nx == S_DMA);
        host_gnt_nx = (state_nx == S_HOST);
        case (state_nx)
            S_DMA:     owner_nx = 2'd1;
            S_HOST:    owner_nx = 2'd2;
            S_RELEASE: owner_nx = 2'd3;
            default:   owner_nx = 2'd0;
        endcase
        if (halt_nx)                    hc_nx = '0;
        else if (bus.halt_cycles == '1) hc_nx = bus.halt_cycles;
        else                            hc_nx = bus.halt_cycles + 16'd1;
    end

    // State and registered outputs
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state           <= S_CPU;
            ctr             <= '0;
            cool            <= '0;
            bus.halt_b      <= 1'b1;
            bus.dma_gnt     <= 1'b0;
            bus.host_gnt    <= 1'b0;
            bus.owner       <= 2'd0;
            bus.halt_cycles <= '0;
        end else begin
            state           <= state_nx;
            ctr             <= ctr_nx;
            cool            <= cool_nx;
            bus.halt_b      <= halt_nx;
            bus.dma_gnt     <= dma_gnt_nx;
            bus.host_gnt    <= host_gnt_nx;
            bus.owner       <= owner_nx;
            bus.halt_cycles <= hc_nx;
        end
    end

    // Memory bus steered by the current owner
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        case (bus.owner)
            2'd0: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_we    = bus.cpu_we;
            end
            2'd1: bus.mem_addr = bus.dma_addr;
            2'd2: begin
                bus.mem_addr  = bus.host_addr;
                bus.mem_wdata = bus.host_wdata;
                bus.mem_we    = bus.host_we & bus.host_gnt;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the arbitration rules.
module tb_bus_arbiter;
    localparam int HL = 12;
    localparam int CD = 1;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bus_arbiter_if #(.ADDR_W(16)) bus ();

    bus_arbiter #(.HALT_LATENCY(HL), .COOLDOWN(CD), .ADDR_W(16)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    // Model: halted flag, cycles spent waiting for the halt, who holds the
    // bus (0 cpu/waiting, 1 dma, 2 host, 3 nobody), cooldown left, halt count.
    typedef struct {
        bit halt;
        int wait_n;
        int own;
        int cool;
        int hc;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mdl_step(mdl_t m, bit dreq, bit hreq, bit cce);
        mdl_t r = m;
        if (!m.halt) begin
            if (dreq || hreq) begin
                r.halt   = 1'b1;
                r.wait_n = 1;
            end
        end else if (m.wait_n > 0) begin
            if (m.wait_n >= HL) begin
                r.wait_n = 0;
                r.own    = dreq ? 1 : (hreq ? 2 : 3);
                r.cool   = CD;
            end else begin
                r.wait_n = m.wait_n + 1;
            end
        end else begin
            case (m.own)
                1: if (!dreq) begin r.own = hreq ? 2 : 3; r.cool = CD; end
                2: begin
                    if (dreq) r.own = 1;
                    else if (!hreq) begin r.own = 3; r.cool = CD; end
                end
                default: begin
                    if (dreq)            r.own = 1;
                    else if (hreq)       r.own = 2;
                    else if (m.cool > 0) r.cool = m.cool - 1;
                    else if (cce) begin r.halt = 1'b0; r.own = 0; end
                end
            endcase
        end
        r.hc = r.halt ? ((m.hc < 65535) ? m.hc + 1 : 65535) : 0;
        return r;
    endfunction

    // Advance the model on every clock; reset mirrors the DUT's async reset
    always @(posedge sysclk or posedge reset) begin
        if (reset) mdl <= '{halt: 1'b0, wait_n: 0, own: 0, cool: 0, hc: 0};
        else       mdl <= mdl_step(mdl, bus.dma_req & bus.enable, bus.host_req, bus.cpu_cycle_end);
    end

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic idle_inputs();
        bus.enable = 1'b1; bus.cpu_cycle_end = 1'b0;
        bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'h5A; bus.cpu_we = 1'b0;
        bus.dma_req = 1'b0; bus.dma_addr = 16'h4000;
        bus.host_req = 1'b0; bus.host_addr = 16'h8000; bus.host_wdata = 8'hC3; bus.host_we = 1'b0;
    endtask

    // Let the arbiter drain back to the CPU on cycle-boundary pulses
    task automatic back_to_cpu(input string tag);
        bit ok = 1'b0;
        bus.dma_req = 1'b0; bus.host_req = 1'b0; bus.cpu_cycle_end = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (bus.halt_b === 1'b1) ok = 1'b1;
        end
        bus.cpu_cycle_end = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_return: halt_b never rose, expected 1", tag); end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (bus.halt_b !== 1'b1 || bus.owner !== 2'd0 || bus.dma_gnt !== 1'b0 ||
            bus.host_gnt !== 1'b0 || bus.halt_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: halt_b=%b owner=%0d dma_gnt=%b host_gnt=%b hc=%0d, expected 1 0 0 0 0",
                     bus.halt_b, bus.owner, bus.dma_gnt, bus.host_gnt, bus.halt_cycles);
        end
        checks++;
        if (bus.mem_addr !== 16'h1234 || bus.mem_wdata !== 8'h5A) begin
            errors++;
            $display("FAIL reset_cpu_mux: mem_addr=%h wdata=%h, expected 1234 5a", bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    // DMA latency, halt count, then release aligned to cpu_cycle_end every 4
    task automatic test_dma_latency();
        bit saw3 = 1'b0, rose = 1'b0;
        bus.dma_req = 1'b1; bus.dma_addr = 16'($urandom);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) begin
                checks++;
                if (bus.halt_b !== 1'b0 || bus.owner !== 2'd0) begin
                    errors++; $display("FAIL lat_halt: halt_b=%b owner=%0d, expected 0 0", bus.halt_b, bus.owner);
                end
            end
            if (n == 12) begin
                checks++;
                if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL lat_early: dma_gnt=%b at cycle 12, expected 0", bus.dma_gnt); end
            end
            if (n == 13) begin
                checks++;
                if (bus.dma_gnt !== 1'b1 || bus.owner !== 2'd1 || bus.mem_addr !== bus.dma_addr || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_grant: dma_gnt=%b owner=%0d mem_addr=%h we=%b, expected 1 1 %h 0",
                             bus.dma_gnt, bus.owner, bus.mem_addr, bus.mem_we, bus.dma_addr);
                end
            end
            if (n == 20) begin
                checks++;
                if (bus.halt_cycles !== 16'd20) begin errors++; $display("FAIL halt_count: hc=%0d, expected 20", bus.halt_cycles); end
            end
        end
        bus.dma_req = 1'b0;
        for (int k = 1; k <= 40 && !rose; k++) begin
            bus.cpu_cycle_end = (k % 4 == 0);
            tick();
            if (bus.owner === 2'd3) saw3 = 1'b1;
            if (bus.halt_b === 1'b1) begin
                rose = 1'b1;
                checks++;
                if (bus.owner !== 2'd0 || !saw3 || bus.cpu_cycle_end !== 1'b1 || bus.halt_cycles !== 16'd0) begin
                    errors++;
                    $display("FAIL release: owner=%0d saw_none=%b aligned=%b hc=%0d, expected 0 1 1 0",
                             bus.owner, saw3, bus.cpu_cycle_end, bus.halt_cycles);
                end
            end
        end
        bus.cpu_cycle_end = 1'b0;
        if (!rose) begin checks++; errors++; $display("FAIL release_timeout: halt_b stayed 0, expected 1"); end
    endtask

    task automatic wait_dma_gnt(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (bus.dma_gnt === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_gnt_timeout: dma_gnt=0, expected 1", tag); end
    endtask

    task automatic test_host_after_dma();
        bus.dma_req = 1'b1; bus.host_req = 1'b1; bus.host_we = 1'b0;
        bus.host_addr = 16'($urandom); bus.host_wdata = 8'($urandom);
        wait_dma_gnt("dma_host");
        tick(); tick();
        bus.dma_req = 1'b0; bus.host_we = 1'b1;
        tick();
        checks++;
        if (bus.dma_gnt !== 1'b0 || bus.host_gnt !== 1'b1 || bus.halt_b !== 1'b0 || bus.owner !== 2'd2 ||
            bus.mem_we !== 1'b1 || bus.mem_addr !== bus.host_addr || bus.mem_wdata !== bus.host_wdata) begin
            errors++;
            $display("FAIL host_handoff: dma_gnt=%b host_gnt=%b halt_b=%b owner=%0d we=%b addr=%h, expected 0 1 0 2 1 %h",
                     bus.dma_gnt, bus.host_gnt, bus.halt_b, bus.owner, bus.mem_we, bus.mem_addr, bus.host_addr);
        end
        bus.host_we = 1'b0;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL host_we_follow: mem_we=%b, expected 0", bus.mem_we); end
        bus.host_req = 1'b0;
        tick();
        checks++;
        if (bus.owner !== 2'd3 || bus.host_gnt !== 1'b0) begin
            errors++; $display("FAIL host_release: owner=%0d host_gnt=%b, expected 3 0", bus.owner, bus.host_gnt);
        end
        back_to_cpu("host");
    endtask

    task automatic test_dma_in_release();
        bit in_rel = 1'b0, glitch = 1'b0;
        bus.dma_req = 1'b1;
        wait_dma_gnt("rel");
        bus.dma_req = 1'b0; bus.cpu_cycle_end = 1'b0;
        for (int i = 0; i < 5 && !in_rel; i++) begin
            tick();
            if (bus.halt_b !== 1'b0) glitch = 1'b1;
            if (bus.owner === 2'd3) in_rel = 1'b1;
        end
        bus.dma_req = 1'b1;
        tick();
        checks++;
        if (!in_rel || glitch || bus.dma_gnt !== 1'b1 || bus.halt_b !== 1'b0 || bus.owner !== 2'd1) begin
            errors++;
            $display("FAIL rel_regrant: in_rel=%b glitch=%b dma_gnt=%b halt_b=%b owner=%0d, expected 1 0 1 0 1",
                     in_rel, glitch, bus.dma_gnt, bus.halt_b, bus.owner);
        end
        back_to_cpu("rel");
    endtask

    task automatic test_reset_mid_dma();
        bus.dma_req = 1'b1;
        wait_dma_gnt("rst");
        reset = 1'b1;
        #1;
        checks++;
        if (bus.halt_b !== 1'b1 || bus.dma_gnt !== 1'b0 || bus.owner !== 2'd0 || bus.halt_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_dma: halt_b=%b dma_gnt=%b owner=%0d hc=%0d, expected 1 0 0 0",
                     bus.halt_b, bus.dma_gnt, bus.owner, bus.halt_cycles);
        end
        tick();
        reset = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            tick();
            if (n == 1) begin
                checks++;
                if (bus.halt_b !== 1'b0 || bus.owner !== 2'd0) begin
                    errors++; $display("FAIL post_reset_halt: halt_b=%b owner=%0d, expected 0 0", bus.halt_b, bus.owner);
                end
            end
            if (n == 12 || n == 13) begin
                checks++;
                if (bus.dma_gnt !== (n == 13)) begin
                    errors++; $display("FAIL post_reset_lat: cycle %0d dma_gnt=%b, expected %0d", n, bus.dma_gnt, n == 13);
                end
            end
        end
        back_to_cpu("rst");
    endtask

    task automatic test_enable_low();
        bit bad = 1'b0;
        bus.enable = 1'b0; bus.dma_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus.cpu_cycle_end = ($urandom_range(0, 3) == 0);
            tick();
            if (bus.halt_b !== 1'b1 || bus.owner !== 2'd0 || bus.dma_gnt !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL enable_low: halt_b=%b owner=%0d dma_gnt=%b, expected 1 0 0", bus.halt_b, bus.owner, bus.dma_gnt);
        end
        bus.dma_req = 1'b0; bus.enable = 1'b1; bus.cpu_cycle_end = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        logic        e_we;
        int          bad = 0;
        for (int i = 0; i < 3000; i++) begin
            case (mdl.own)
                0:       begin e_addr = bus.cpu_addr;  e_wd = bus.cpu_wdata;  e_we = bus.cpu_we;  end
                1:       begin e_addr = bus.dma_addr;  e_wd = 8'h00;          e_we = 1'b0;        end
                2:       begin e_addr = bus.host_addr; e_wd = bus.host_wdata; e_we = bus.host_we; end
                default: begin e_addr = 16'h0;         e_wd = 8'h00;          e_we = 1'b0;        end
            endcase
            checks++;
            if (bus.halt_b !== !mdl.halt || bus.owner !== 2'(mdl.own) || bus.dma_gnt !== (mdl.own == 1) ||
                bus.host_gnt !== (mdl.own == 2) || bus.halt_cycles !== 16'(mdl.hc) ||
                bus.mem_addr !== e_addr || bus.mem_wdata !== e_wd || bus.mem_we !== e_we) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random[%0d]: halt_b=%b owner=%0d gnt=%b%b hc=%0d mem=%h/%h/%b, expected %b %0d %b%b %0d %h/%h/%b",
                             i, bus.halt_b, bus.owner, bus.dma_gnt, bus.host_gnt, bus.halt_cycles,
                             bus.mem_addr, bus.mem_wdata, bus.mem_we, !mdl.halt, mdl.own, mdl.own == 1,
                             mdl.own == 2, mdl.hc, e_addr, e_wd, e_we);
                bad++;
            end
            if ($urandom_range(0, 11) == 0) bus.dma_req  = ~bus.dma_req;
            if ($urandom_range(0, 9) == 0)  bus.host_req = ~bus.host_req;
            bus.enable        = ($urandom_range(0, 15) != 0);
            bus.cpu_cycle_end = ($urandom_range(0, 3) == 0);
            bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 8'($urandom); bus.cpu_we = 1'($urandom);
            bus.dma_addr = 16'($urandom);
            bus.host_addr = 16'($urandom); bus.host_wdata = 8'($urandom); bus.host_we = 1'($urandom);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_dma_latency();
        test_host_after_dma();
        test_dma_in_release();
        test_reset_mid_dma();
        test_enable_low();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
